// File: rtl/mux_scan_n.sv
// Registered N-channel selector with manual select and masked auto-scan.
// Wrap strobe is deferred so it lines up with the first sample of a new sweep.
module mux_scan_n #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [N_CH*W-1:0] iData,
  input  logic [SELW-1:0]   iSel,
  input  logic              iMode,
  input  logic              iEn,
  input  logic [N_CH-1:0]   iMask,
  output logic [W-1:0]      oY,
  output logic [SELW-1:0]   oCh,
  output logic              oValid,
  output logic              oWrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [W-1:0]    chan [N_CH];
  logic [SELW-1:0] ch_q, ch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            pend_q, pend_d;
  logic [W-1:0]    y_q, y_d;
  logic [SELW-1:0] och_q, och_d;
  logic            valid_q, valid_d;
  logic            wrap_q, wrap_d;

  logic [SELW-1:0] first_idx;
  logic [SELW-1:0] next_idx;
  logic            any_m;
  logic            ch_on;
  logic            sel_ok;
  logic            is_man, is_entry, is_none, is_skip, is_run;

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    assign chan[k] = iData[k*W +: W];
  end

  function automatic logic [SELW-1:0] step_idx(
    input logic [SELW-1:0] c,
    input int              i
  );
    int s;
    s = int'(c) + i;
    if (s >= N_CH) s = s - N_CH;
    return SELW'(s);
  endfunction

  // Priority searches: lowest set bit, and first set bit after ch (cyclic,
  // ending on ch itself so a lone channel re-selects itself).
  always_comb begin
    first_idx = '0;
    next_idx  = ch_q;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (iMask[i]) first_idx = SELW'(i);
    end
    for (int i = N_CH; i >= 1; i--) begin
      if (iMask[step_idx(ch_q, i)]) next_idx = step_idx(ch_q, i);
    end
  end

  assign any_m  = |iMask;
  assign ch_on  = iMask[ch_q];
  assign sel_ok = int'(iSel) < N_CH;

  assign is_man   = !iMode;
  assign is_entry = iMode && !mode_q;
  assign is_none  = iMode && mode_q && !any_m;
  assign is_skip  = iMode && mode_q && any_m && !ch_on;
  assign is_run   = iMode && mode_q && any_m && ch_on;

  always_comb begin
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    y_d     = y_q;
    och_d   = och_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (iEn) begin
      mode_d = iMode;
      unique case (1'b1)
        is_man: begin
          cnt_d = '0;
          och_d = iSel;
          if (sel_ok) begin
            y_d     = chan[iSel];
            valid_d = 1'b1;
          end else begin
            y_d = '0;
          end
        end
        is_entry: begin
          ch_d   = first_idx;
          cnt_d  = '0;
          pend_d = 1'b0;
        end
        is_none: begin
          y_d = '0;
        end
        is_skip: begin
          ch_d   = next_idx;
          cnt_d  = '0;
          pend_d = next_idx <= ch_q;
        end
        is_run: begin
          y_d     = chan[ch_q];
          och_d   = ch_q;
          valid_d = 1'b1;
          if (cnt_q == '0) begin
            wrap_d = pend_q;
            pend_d = 1'b0;
          end
          if (cnt_q == CW'(DWELL - 1)) begin
            cnt_d  = '0;
            ch_d   = next_idx;
            pend_d = next_idx <= ch_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ch_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
      y_q     <= '0;
      och_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      och_q   <= och_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign oY     = y_q;
  assign oCh    = och_q;
  assign oValid = valid_q;
  assign oWrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: three instances (8ch/dwell2, 6ch/dwell2, 8ch/dwell1)
// share stimulus; expected outputs are queued and checked by a monitor.
module tb_mux_scan_n;

  logic        iClk;
  logic        iRst;
  logic [31:0] data;
  logic [2:0]  sel;
  logic        mode;
  logic        en;
  logic [7:0]  mask;

  logic [3:0] ya  [3];
  logic [2:0] cha [3];
  logic       va  [3];
  logic       wa  [3];

  int checks;
  int failures;

  typedef struct {
    int    d;
    string nm;
    int    v;
    int    y;
    int    ch;
    int    w;
  } exp_t;

  exp_t sb[$];

  mux_scan_n #(.N_CH(8), .W(4), .DWELL(2)) u8 (
    .iClk(iClk), .iRst(iRst), .iData(data), .iSel(sel),
    .iMode(mode), .iEn(en), .iMask(mask),
    .oY(ya[0]), .oCh(cha[0]), .oValid(va[0]), .oWrap(wa[0])
  );

  mux_scan_n #(.N_CH(6), .W(4), .DWELL(2)) u6 (
    .iClk(iClk), .iRst(iRst), .iData(data[23:0]), .iSel(sel),
    .iMode(mode), .iEn(en), .iMask(mask[5:0]),
    .oY(ya[1]), .oCh(cha[1]), .oValid(va[1]), .oWrap(wa[1])
  );

  mux_scan_n #(.N_CH(8), .W(4), .DWELL(1)) u1 (
    .iClk(iClk), .iRst(iRst), .iData(data), .iSel(sel),
    .iMode(mode), .iEn(en), .iMask(mask),
    .oY(ya[2]), .oCh(cha[2]), .oValid(va[2]), .oWrap(wa[2])
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Expect fields with value < 0 are not compared.
  task automatic ex(input int d, input string nm, input int v,
                    input int y, input int ch, input int w);
    exp_t e;
    e.d = d; e.nm = nm; e.v = v; e.y = y; e.ch = ch; e.w = w;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge iClk);
  endtask

  always @(posedge iClk) begin
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.v >= 0) chk({e.nm, ".valid"}, 32'(va[e.d]), e.v);
      if (e.y >= 0) chk({e.nm, ".y"}, 32'(ya[e.d]), e.y);
      if (e.ch >= 0) chk({e.nm, ".ch"}, 32'(cha[e.d]), e.ch);
      if (e.w >= 0) chk({e.nm, ".wrap"}, 32'(wa[e.d]), e.w);
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    iRst = 1'b1;
    data = 32'h7654_3210;
    sel  = 3'd0;
    mode = 1'b0;
    en   = 1'b1;
    mask = 8'hFF;
    #3;
    chk("rst.y", 32'(ya[0]), 0);
    chk("rst.valid", 32'(va[0]), 0);
    chk("rst.wrap", 32'(wa[0]), 0);
    @(negedge iClk);
    iRst = 1'b0;

    sel = 3'd3;
    ex(0, "man3", 1, 3, 3, 0);
    ex(1, "man3_n6", 1, 3, 3, 0);
    tick();
    sel = 3'd7;
    ex(0, "man7", 1, 7, 7, 0);
    ex(1, "man7_n6", 0, 0, -1, 0);
    tick();

    mode = 1'b1;
    mask = 8'hFF;
    ex(0, "entry", 0, 7, 7, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      ex(0, "sweep", 1, i / 2, i / 2, 0);
      tick();
    end
    ex(0, "sweep_wrap", 1, 0, 0, 1);
    tick();
    ex(0, "sweep_after", 1, 0, 0, 0);
    tick();

    mode = 1'b0;
    sel  = 3'd0;
    ex(0, "man0", 1, 0, 0, 0);
    tick();
    mode = 1'b1;
    mask = 8'b1010_0100;
    ex(0, "mentry", 0, -1, -1, 0);
    tick();
    ex(0, "mask_a", 1, 2, 2, 0); tick();
    ex(0, "mask_b", 1, 2, 2, 0); tick();
    ex(0, "mask_c", 1, 5, 5, 0); tick();
    ex(0, "mask_d", 1, 5, 5, 0); tick();
    ex(0, "mask_e", 1, 7, 7, 0); tick();
    ex(0, "mask_f", 1, 7, 7, 0); tick();
    ex(0, "mask_g", 1, 2, 2, 1); tick();
    ex(0, "mask_h", 1, 2, 2, 0); tick();
    mask = 8'b1000_0100;
    ex(0, "skip5", 0, 2, 2, 0); tick();
    ex(0, "skip_7a", 1, 7, 7, 0); tick();
    ex(0, "skip_7b", 1, 7, 7, 0); tick();
    ex(0, "skip_2", 1, 2, 2, 1); tick();

    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex(0, "hold", 0, 2, 2, 0);
      tick();
    end
    en = 1'b1;
    ex(0, "resume2", 1, 2, 2, 0); tick();
    ex(0, "resume7", 1, 7, 7, 0); tick();

    mode = 1'b0;
    sel  = 3'd1;
    ex(0, "tog_man", 1, 1, 1, 0); tick();
    mode = 1'b1;
    ex(0, "tog_entry", 0, 1, 1, 0); tick();
    ex(0, "tog_first", 1, 2, 2, 0); tick();

    mask = 8'h00;
    ex(0, "none_a", 0, 0, 2, 0); tick();
    ex(0, "none_b", 0, 0, 2, 0); tick();

    mask = 8'hFF;
    ex(0, "pre_2", 1, 2, 2, 0); tick();
    ex(0, "pre_3a", 1, 3, 3, 0); tick();
    ex(0, "pre_3b", 1, 3, 3, 0); tick();
    ex(0, "pre_4a", 1, 4, 4, 0); tick();
    ex(0, "pre_4b", 1, 4, 4, 0); tick();
    ex(0, "pre_5", 1, 5, 5, 0); tick();

    #2;
    iRst = 1'b1;
    #1;
    chk("arst.y", 32'(ya[0]), 0);
    chk("arst.ch", 32'(cha[0]), 0);
    chk("arst.valid", 32'(va[0]), 0);
    chk("arst.wrap", 32'(wa[0]), 0);
    chk("arst.ch_q", 32'(u8.ch_q), 0);
    chk("arst.cnt_q", 32'(u8.cnt_q), 0);
    tick();
    iRst = 1'b0;

    mode = 1'b1;
    mask = 8'b0001_0000;
    ex(2, "d1_entry", 0, -1, -1, 0); tick();
    ex(2, "d1_first", 1, 4, 4, -1); tick();
    for (int i = 0; i < 4; i++) begin
      ex(2, "d1_wrap", 1, 4, 4, 1);
      tick();
    end

    tick();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
